// File: rtl/clock_display_scan.sv
// Eight-digit multiplexed seven-segment scanner for the clock core's BCD time.
// Outputs are registered one clock behind the selected digit; a prescaler paces the scan and a second counter paces the adjust blink.
module clock_display_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic       Adj_Hour,
  input  logic       Adj_Min,
  input  logic       timemode,
  output logic [7:0] HEX,
  output logic [7:0] An
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blk_cnt;
  logic          blink_ph;
  logic          tick;
  logic          blk_wrap;

  assign tick     = (div_cnt == DW'(SCAN_DIV - 1));
  assign blk_wrap = (blk_cnt == BW'(BLINK_TICKS - 1));

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'h86;
    endcase
    return s;
  endfunction

  logic [3:0] nib;
  logic       is_dash;
  logic       blank;
  logic [7:0] hex_nxt;

  // Fields are decoded straight from the live inputs so a BCD change lands on the next edge.
  always_comb begin
    nib     = 4'd0;
    is_dash = 1'b0;
    blank   = 1'b0;
    case (idx)
      3'd7: begin
        nib   = hour_bcd[7:4];
        blank = (Adj_Hour && blink_ph) || (timemode && hour_bcd[7:4] == 4'd0);
      end
      3'd6: begin
        nib   = hour_bcd[3:0];
        blank = Adj_Hour && blink_ph;
      end
      3'd4: begin
        nib   = min_bcd[7:4];
        blank = Adj_Min && blink_ph;
      end
      3'd3: begin
        nib   = min_bcd[3:0];
        blank = Adj_Min && blink_ph;
      end
      3'd1:    nib = sec_bcd[7:4];
      3'd0:    nib = sec_bcd[3:0];
      default: is_dash = 1'b1;
    endcase
    if (blank)        hex_nxt = SEG_BLANK;
    else if (is_dash) hex_nxt = SEG_DASH;
    else              hex_nxt = seg(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      idx      <= 3'd0;
      blk_cnt  <= '0;
      blink_ph <= 1'b0;
      HEX      <= 8'hFF;
      An       <= 8'hFF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        idx <= idx + 3'd1;
        if (blk_wrap) begin
          blk_cnt  <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
      // Counters keep running while disabled so the scan phase survives enable toggles.
      if (en) begin
        HEX <= hex_nxt;
        An  <= ~(8'd1 << idx);
      end else begin
        HEX <= 8'hFF;
        An  <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: time-indexed reference model feeding a queue, monitor compares every output cycle.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] hour_bcd = 8'h00;
  logic [7:0] min_bcd = 8'h00;
  logic [7:0] sec_bcd = 8'h00;
  logic       Adj_Hour = 1'b0;
  logic       Adj_Min = 1'b0;
  logic       timemode = 1'b0;
  logic [7:0] HEX;
  logic [7:0] An;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .en(en),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .Adj_Hour(Adj_Hour), .Adj_Min(Adj_Min), .timemode(timemode),
    .HEX(HEX), .An(An)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16];
  logic [15:0] exp_q [$];
  int n = 0;       // non-reset edges since reset released
  int checks = 0;
  int passed = 0;
  int cyc = 0;

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86, 8'h86};
  end

  // Expected {An,HEX} after the edge numbered k, from wall-clock arithmetic alone.
  function automatic logic [15:0] model(input int k);
    int         digit;
    int         ph;
    logic [3:0] v;
    logic       blk;
    logic       dash;
    logic [7:0] hx;
    if (reset) return 16'hFFFF;
    if (!en)   return 16'hFFFF;
    digit = (k / SD) % 8;
    ph    = (k / (SD * BT)) % 2;
    dash  = (digit == 5) || (digit == 2);
    case (digit)
      7: v = hour_bcd[7:4];
      6: v = hour_bcd[3:0];
      4: v = min_bcd[7:4];
      3: v = min_bcd[3:0];
      1: v = sec_bcd[7:4];
      0: v = sec_bcd[3:0];
      default: v = 4'd0;
    endcase
    blk = ((digit == 7 || digit == 6) && Adj_Hour && ph == 1) ||
          ((digit == 4 || digit == 3) && Adj_Min && ph == 1) ||
          (digit == 7 && timemode && hour_bcd[7:4] == 4'd0);
    hx = blk ? 8'hFF : (dash ? 8'hBF : seg_tab[v]);
    return {~(8'd1 << digit), hx};
  endfunction

  task automatic step();
    exp_q.push_back(model(n));
    if (reset) n = 0;
    else       n = n + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Monitor: outputs are presented every clock, so one queued expectation is consumed per edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({An, HEX} !== e)
          $display("FAIL out cycle %0d: An=%h HEX=%h, required An=%h HEX=%h",
                   cyc, An, HEX, e[15:8], e[7:0]);
        else
          passed++;
      end
    end
  end

  initial begin
    // Reset and plain scan at 12:34:56.
    reset = 1'b1; en = 1'b1;
    hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
    run(3);
    reset = 1'b0;
    run(40);
    // Enable drop; counters keep going.
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(24);
    // Blink minutes, then hours too, then release minutes mid-phase.
    Adj_Min = 1'b1;
    run(64);
    Adj_Hour = 1'b1;
    run(64);
    while (((n / (SD * BT)) % 2) != 1) step();
    Adj_Min = 1'b0;
    run(20);
    Adj_Hour = 1'b0;
    // 12-hour blanking of leading zero.
    timemode = 1'b1; hour_bcd = 8'h08;
    run(32);
    hour_bcd = 8'h10;
    run(32);
    timemode = 1'b0;
    // Invalid BCD nibble.
    sec_bcd = 8'h5C;
    run(32);
    // Reset while idx = 5, then restart from digit 0.
    while (((n / SD) % 8) != 5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(16);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) hour_bcd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) min_bcd  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) sec_bcd  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) Adj_Hour = 1'($urandom);
      if ($urandom_range(0, 15) == 0) Adj_Min  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) timemode = 1'($urandom);
      step();
    end
    reset = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
